// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: PC-driven fetch with skid buffer, redirect squash and loader port arbitration
module imem_fetch_arbiter #(
  parameter int          ADDR_W   = 20,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  input  logic              load_req,
  output logic              load_gnt,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {FETCH, LOAD} state_t;
  state_t            state;
  logic [31:0]       pc, pending_pc, skid_pc, issue_pc;
  logic [DATA_W-1:0] skid_data;
  logic              skid_valid, pending, acc, out_free, issue;
  logic [1:0]        next_occ;
  assign acc      = inst_valid & inst_ready;
  assign out_free = !inst_valid | acc;
  assign next_occ = 2'(inst_valid) + 2'(skid_valid) - 2'(acc) + 2'(pending);
  assign issue    = rst_n & (state == FETCH) & !load_req & (redirect | (next_occ <= 2'd1));
  assign issue_pc = redirect ? redirect_pc : pc;
  assign mem_en    = (state == LOAD) ? load_we : issue;
  assign mem_we    = (state == LOAD) & load_we;
  assign mem_addr  = (state == LOAD) ? load_addr : (issue ? issue_pc[ADDR_W+1:2] : '0);
  assign mem_wdata = (state == LOAD) ? load_wdata : '0;
  // Port ownership FSM plus fetch pipeline: output register, skid entry and in-flight read tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      load_gnt   <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_pc    <= '0;
      pending    <= 1'b0;
      pending_pc <= '0;
    end else if (state == LOAD) begin
      if (!load_req) begin
        state    <= FETCH;
        load_gnt <= 1'b0;
        pc       <= RESET_PC;
      end
    end else if (load_req) begin
      state      <= LOAD;
      load_gnt   <= 1'b1;
      inst_valid <= 1'b0;
      skid_valid <= 1'b0;
      pending    <= 1'b0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
      skid_valid <= 1'b0;
      pending    <= 1'b1;
      pending_pc <= redirect_pc;
      pc         <= redirect_pc + 32'd4;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= pc;
        pc         <= pc + 32'd4;
      end
      if (out_free) begin
        inst_valid <= skid_valid | pending;
        if (skid_valid) begin
          inst_data <= skid_data;
          inst_pc   <= skid_pc;
        end else if (pending) begin
          inst_data <= mem_rdata;
          inst_pc   <= pending_pc;
        end
      end
      skid_valid <= out_free ? (skid_valid & pending) : (skid_valid | pending);
      if (pending) begin
        skid_data <= mem_rdata;
        skid_pc   <= pending_pc;
      end
    end
  end
endmodule
